arb_requester: RTL and testbench

//   Requester-side agent for the two-client req/grant arbiter. Queues burst

---
 rtl/arb_pkg.sv | 16 +
 rtl/sync_fifo.sv | 48 ++++
 rtl/arb_requester.sv | 141 ++++++++++++++
 tb/tb_arb_requester.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the arbiter requester agents: FSM state encoding
// and default parameter values.
package arb_pkg;

  localparam int ARB_DEPTH   = 4;
  localparam int ARB_LEN_W   = 4;
  localparam int ARB_TIMEOUT = 16;
  localparam int ARB_CNT_W   = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2
  } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-bit read/write pointers so full and empty
// are distinguished without a separate occupancy counter.
module sync_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  // Pointers agree in the low bits when full or empty; the wrap bit tells them apart.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // NOTE: storage is deliberately left out of reset; the pointers alone define
  // which entries are valid, so clearing the array would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/arb_requester.sv
// Requester-side agent for a two-client req/grant arbiter: queues burst jobs,
// holds req for a whole burst, leaves a one-cycle gap between jobs, flags starvation.
module arb_requester
  import arb_pkg::*;
#(
  parameter int DEPTH   = ARB_DEPTH,
  parameter int LEN_W   = ARB_LEN_W,
  parameter int TIMEOUT = ARB_TIMEOUT,
  parameter int CNT_W   = ARB_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             job_valid,
  output logic             job_ready,
  input  logic [LEN_W-1:0] job_len,
  output logic             req,
  input  logic             gnt,
  output logic             beat_valid,
  output logic             beat_last,
  output logic             starve,
  input  logic             starve_clr,
  output logic [CNT_W-1:0] done_cnt
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] TIMEOUT_W = WAIT_W'(TIMEOUT);

  state_t            state;
  state_t            state_next;
  logic [LEN_W-1:0]  remaining;
  logic [LEN_W-1:0]  remaining_next;
  logic [LEN_W-1:0]  head_len;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_pop;
  logic              fifo_push;
  logic [WAIT_W-1:0] wait_cnt;
  logic              waiting;
  logic              starve_set;

  assign fifo_push = job_valid && job_ready;
  assign job_ready = !fifo_full;

  sync_fifo #(
    .WIDTH (LEN_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (job_len),
    .pop       (fifo_pop),
    .pop_data  (head_len),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // req comes straight from the state register, so it is glitch-free toward the arbiter.
  assign req        = (state == REQ);
  assign beat_valid = req && gnt;
  assign beat_last  = beat_valid && (remaining == '0);

  // NOTE: every output of this block gets a default before the case so no path
  // leaves a value unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next     = state;
    remaining_next = remaining;
    fifo_pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop       = 1'b1;
          remaining_next = head_len;
          state_next     = REQ;
        end
      end
      REQ: begin
        if (gnt) begin
          if (remaining == '0) state_next     = GAP;
          else                 remaining_next = remaining - LEN_W'(1);
        end
      end
      GAP: begin
        if (!fifo_empty) begin
          fifo_pop       = 1'b1;
          remaining_next = head_len;
          state_next     = REQ;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= '0;
    end else begin
      state     <= state_next;
      remaining <= remaining_next;
    end
  end

  // Starve is requested on the cycle the counter reaches TIMEOUT and on every
  // saturated ungranted cycle after that, which lets set win over clear.
  assign waiting    = req && !gnt;
  assign starve_set = waiting && (wait_cnt >= TIMEOUT_W - WAIT_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (waiting) begin
      if (wait_cnt != TIMEOUT_W) wait_cnt <= wait_cnt + WAIT_W'(1);
    end else begin
      wait_cnt <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve <= 1'b0;
    end else if (starve_set) begin
      starve <= 1'b1;
    end else if (starve_clr) begin
      starve <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_cnt <= '0;
    end else if (beat_last) begin
      done_cnt <= done_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_arb_requester.sv
// Directed bench for arb_requester: single instance driven directly, then a
// pair of instances sharing a small round-robin arbiter.
module tb_arb_requester;

  logic       clk = 1'b0;
  logic       rst;
  logic       job_valid, job_ready;
  logic [3:0] job_len;
  logic       req, gnt, beat_valid, beat_last, starve, starve_clr;
  logic [7:0] done_cnt;

  // second environment: two agents plus arbiter
  logic       jv0, jv1, jr0, jr1, r0, r1, g0, g1, bv0, bv1, bl0, bl1, sv0, sv1;
  logic [7:0] dc0, dc1;
  logic       pri;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_done = 0;
  int beats    = 0;
  bit prev_last = 0;
  bit exp_q[$];

  always #5 clk = ~clk;

  arb_requester u_dut (
    .clk(clk), .rst(rst), .job_valid(job_valid), .job_ready(job_ready),
    .job_len(job_len), .req(req), .gnt(gnt), .beat_valid(beat_valid),
    .beat_last(beat_last), .starve(starve), .starve_clr(starve_clr),
    .done_cnt(done_cnt)
  );

  arb_requester u_c0 (
    .clk(clk), .rst(rst), .job_valid(jv0), .job_ready(jr0), .job_len(4'd1),
    .req(r0), .gnt(g0), .beat_valid(bv0), .beat_last(bl0), .starve(sv0),
    .starve_clr(1'b0), .done_cnt(dc0)
  );

  arb_requester u_c1 (
    .clk(clk), .rst(rst), .job_valid(jv1), .job_ready(jr1), .job_len(4'd1),
    .req(r1), .gnt(g1), .beat_valid(bv1), .beat_last(bl1), .starve(sv1),
    .starve_clr(1'b0), .done_cnt(dc1)
  );

  // Round-robin arbiter: priority passes to the other client after a finished job.
  assign g0 = r0 && (!r1 || !pri);
  assign g1 = r1 && (!r0 || pri);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      pri <= 1'b0;
    else if (bl0) pri <= 1'b1;
    else if (bl1) pri <= 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: scoreboard push on acceptance, pop/compare on each beat.
  task automatic step();
    @(negedge clk);
    if (job_valid && job_ready) begin
      for (int i = 0; i < int'(job_len); i++) exp_q.push_back(1'b0);
      exp_q.push_back(1'b1);
    end
    if (prev_last) check("gap_req_low", {31'd0, req}, 32'd0);
    prev_last = 0;
    if (beat_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", {31'd0, beat_valid}, 32'd0);
      end else begin
        bit b;
        b = exp_q.pop_front();
        check("beat_last", {31'd0, beat_last}, {31'd0, b});
        if (b) exp_done++;
        prev_last = b;
        beats++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int budget;
    int n_acc;
    int overlap;
    int alt_err;
    int last_owner;
    int diff;
    logic g_pat [6];

    rst = 1'b1; job_valid = 0; job_len = '0; gnt = 0; starve_clr = 0;
    jv0 = 0; jv1 = 0;
    @(posedge clk); #1;
    check("rst_req", {31'd0, req}, 0);
    check("rst_starve", {31'd0, starve}, 0);
    check("rst_done", {24'd0, done_cnt}, 0);
    rst = 1'b0;
    #1;
    check("rst_ready", {31'd0, job_ready}, 1);

    // 1: single-beat job with gnt tied high
    gnt = 1; job_valid = 1; job_len = 4'd0;
    step();
    job_valid = 0;
    check("t1_req_n1", {31'd0, req}, 0);
    step();
    check("t1_req_n2", {31'd0, req}, 1);
    step();
    check("t1_req_after", {31'd0, req}, 0);
    check("t1_done", {24'd0, done_cnt}, exp_done);
    check("t1_done_abs", {24'd0, done_cnt}, 1);

    // 2: four-beat job with preempting grant pattern
    gnt = 0; job_valid = 1; job_len = 4'd3;
    step();
    job_valid = 0;
    step();
    beats = 0;
    g_pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 6; i++) begin
      check("t2_req_held", {31'd0, req}, 1);
      gnt = g_pat[i];
      step();
    end
    check("t2_beats", beats, 4);
    check("t2_req_low", {31'd0, req}, 0);
    check("t2_done", {24'd0, done_cnt}, 2);

    // 3: five jobs into a four-deep FIFO with gnt low
    gnt = 0;
    step();
    n_acc = 0;
    budget = 0;
    while (n_acc < 5 && budget < 20) begin
      job_valid = 1; job_len = 4'(n_acc);
      @(negedge clk);
      if (job_ready) n_acc++;
      #0;
      step_back_align();
      budget++;
    end
    check("t3_accepted", n_acc, 5);
    job_valid = 1; job_len = 4'd9;
    #1;
    check("t3_full_ready", {31'd0, job_ready}, 0);
    @(posedge clk); #1;
    check("t3_still_full", {31'd0, job_ready}, 0);
    job_valid = 0;
    gnt = 1;
    budget = 0;
    while (exp_q.size() > 0 && budget < 100) begin
      step();
      budget++;
    end
    check("t3_drained", {31'd0, exp_q.size() == 0}, 1);
    check("t3_done", {24'd0, done_cnt}, 7);
    step();

    // 4: starvation, clear colliding with set, then grant and clear
    gnt = 0; job_valid = 1; job_len = 4'd0;
    step();
    job_valid = 0;
    step();
    for (int i = 0; i < 15; i++) step();
    check("t4_starve_15", {31'd0, starve}, 0);
    step();
    check("t4_starve_16", {31'd0, starve}, 1);
    starve_clr = 1;
    step();
    check("t4_set_wins", {31'd0, starve}, 1);
    starve_clr = 0; gnt = 1;
    step();
    check("t4_after_gnt", {31'd0, starve}, 1);
    starve_clr = 1; gnt = 0;
    step();
    check("t4_cleared", {31'd0, starve}, 0);
    starve_clr = 0;
    check("t4_done", {24'd0, done_cnt}, exp_done);

    // 5: reset mid-burst with two jobs queued
    step();
    gnt = 0; job_valid = 1; job_len = 4'd3;
    step();
    job_len = 4'd1;
    step();
    job_len = 4'd2;
    step();
    job_valid = 0; gnt = 1;
    step();
    step();
    check("t5_mid_req", {31'd0, req}, 1);
    gnt = 0;
    rst = 1;
    #1;
    check("t5_req_now", {31'd0, req}, 0);
    check("t5_done_zero", {24'd0, done_cnt}, 0);
    exp_q.delete(); exp_done = 0; prev_last = 0;
    @(posedge clk); #1;
    rst = 0;
    for (int i = 0; i < 3; i++) step();
    check("t5_fifo_empty", {31'd0, req}, 0);
    check("t5_ready", {31'd0, job_ready}, 1);
    gnt = 1; job_valid = 1; job_len = 4'd1;
    step();
    job_valid = 0;
    for (int i = 0; i < 4; i++) step();
    check("t5_new_job", {24'd0, done_cnt}, 1);
    check("t5_sb_empty", {31'd0, exp_q.size() == 0}, 1);

    // 6: two agents sharing the arbiter
    gnt = 0;
    jv0 = 1; jv1 = 1;
    overlap = 0; alt_err = 0; last_owner = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (g0 && g1) overlap++;
      if (bl0) begin
        if (last_owner == 0) alt_err++;
        last_owner = 0;
      end
      if (bl1) begin
        if (last_owner == 1) alt_err++;
        last_owner = 1;
      end
      @(posedge clk); #1;
    end
    jv0 = 0; jv1 = 0;
    diff = int'(dc0) - int'(dc1);
    check("t6_overlap", overlap, 0);
    check("t6_alternate", alt_err, 0);
    check("t6_progress0", {31'd0, dc0 >= 8'd20}, 1);
    check("t6_balance", {31'd0, (diff <= 1) && (diff >= -1)}, 1);
    check("t6_starve0", {31'd0, sv0}, 0);
    check("t6_starve1", {31'd0, sv1}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Completes a cycle already at its negedge: scoreboard push, then the edge.
  task automatic step_back_align();
    if (job_valid && job_ready) begin
      for (int i = 0; i < int'(job_len); i++) exp_q.push_back(1'b0);
      exp_q.push_back(1'b1);
    end
    if (beat_valid) check("t3_no_beat", {31'd0, beat_valid}, 0);
    @(posedge clk);
    #1;
  endtask

endmodule
